// File: rtl/memory_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store requesters.
// Data wins ties unless fetch has been passed over STARVE_LIMIT times; a watchdog aborts hung accesses.
module memory_port_arbiter #(
   parameter int BIT_COUNT    = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   // fetch port
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic                    i_gnt,
   output logic                    i_rvalid,
   output logic [BIT_COUNT-1:0]    i_rdata,
   output logic                    i_err,
   // load/store port
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [BIT_COUNT-1:0]    d_wdata,
   input  logic [BIT_COUNT/8-1:0]  d_wmask,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [BIT_COUNT-1:0]    d_rdata,
   output logic                    d_err,
   // shared memory port
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [BIT_COUNT-1:0]    mem_wdata,
   output logic [BIT_COUNT/8-1:0]  mem_wmask,
   input  logic                    mem_ack,
   input  logic [BIT_COUNT-1:0]    mem_rdata,
   // current arbiter state (IDLE=0, BUSY=1, RESP=2)
   output logic [1:0]              dbg_state
);

   // Handshake: a requester holds req and its fields until gnt pulses for one
   // cycle (only ever in IDLE); exactly one rvalid pulse per grant follows,
   // carrying rdata/err, unless reset intervenes.

   localparam int                WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0]   WD_LAST    = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [7:0]        STARVE_MAX = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              owner;       // 0 = fetch, 1 = data
   logic [7:0]        starve_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic              pick_data;
   logic              pick_fetch;
   logic              acc_done;
   logic              acc_timeout;

   assign pick_data  = d_req && (!i_req || (starve_cnt != STARVE_MAX));
   assign pick_fetch = i_req && !pick_data;
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      i_gnt       = 1'b0;
      d_gnt       = 1'b0;
      acc_done    = 1'b0;
      acc_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            // gnt is gated by reset so every output reads 0 while reset is held
            i_gnt = reset && pick_fetch;
            d_gnt = reset && pick_data;
            if (pick_fetch || pick_data) begin
               state_next = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               acc_done   = 1'b1;
               state_next = ST_RESP;
            end else if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
               acc_timeout = 1'b1;
               state_next  = ST_RESP;
            end
         end
         ST_RESP: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner      <= 1'b0;
         starve_cnt <= 8'd0;
         wd_cnt     <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wmask  <= '0;
         i_rvalid   <= 1'b0;
         i_rdata    <= '0;
         i_err      <= 1'b0;
         d_rvalid   <= 1'b0;
         d_rdata    <= '0;
         d_err      <= 1'b0;
      end else begin
         i_rvalid <= 1'b0;
         d_rvalid <= 1'b0;

         if (i_gnt || d_gnt) begin
            owner     <= d_gnt;
            mem_req   <= 1'b1;
            mem_we    <= d_gnt && d_we;
            mem_addr  <= d_gnt ? d_addr  : i_addr;
            mem_wdata <= d_gnt ? d_wdata : '0;
            mem_wmask <= d_gnt ? d_wmask : '0;
            wd_cnt    <= '0;
            // only data grants that overtake a waiting fetch count towards starvation
            starve_cnt <= (d_gnt && i_req) ? starve_cnt + 8'd1 : 8'd0;
         end

         if (state == ST_BUSY) begin
            if (acc_done || acc_timeout) begin
               mem_req <= 1'b0;
               if (owner) begin
                  d_rvalid <= 1'b1;
                  d_rdata  <= (acc_timeout || mem_we) ? '0 : mem_rdata;
                  d_err    <= acc_timeout;
               end else begin
                  i_rvalid <= 1'b1;
                  i_rdata  <= acc_timeout ? '0 : mem_rdata;
                  i_err    <= acc_timeout;
               end
            end else begin
               wd_cnt <= wd_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed and randomized bench for memory_port_arbiter: a transaction-level
// model predicts grants, memory-side fields and responses cycle by cycle.
module tb_memory_port_arbiter;

  localparam int BC    = 32;
  localparam int AW    = 32;
  localparam int SLIM  = 4;
  localparam int TOUT  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid, i_err;
  logic [AW-1:0] i_addr;
  logic [BC-1:0] i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [BC-1:0] d_wdata, d_rdata;
  logic [3:0]    d_wmask;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [BC-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wmask;
  logic [1:0]    dbg_state;

  memory_port_arbiter #(
    .BIT_COUNT(BC), .ADDR_WIDTH(AW), .STARVE_LIMIT(SLIM), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  // scoreboard and model state
  logic [BC:0]   exp_q[$];
  logic [BC-1:0] model_mem[0:7];
  logic [BC-1:0] phys_mem[0:7];
  logic          grant_log[$];
  int checks = 0, failures = 0;
  int cyc = 0, gnt_cyc = 0, rv_cyc = 0, busy_cnt = 0, streak = 0;
  int run_len = 0, last_run = 0, rv_total = 0, d_rv_total = 0;
  int wait_left = 0, next_wait = 0;
  logic outstanding = 0, in_mem = 0, resp_due = 0, cur_data = 0;
  logic f_we;
  logic [AW-1:0] f_addr;
  logic [BC-1:0] f_wdata;
  logic [3:0]    f_wmask;
  logic i_gnt_seen = 0, d_gnt_seen = 0, gnt_i_at_mon = 0;
  logic keep_req = 0, rand_mode = 0, hang = 0, spur = 0, log_en = 0, acc_active = 0;
  logic [BC-1:0] last_i_rdata = '0, last_d_rdata = '0;
  logic last_i_err = 0, last_d_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_req"},   64'(mem_req),   64'd0);
    chk({pfx, "_mem_we"},    64'(mem_we),    64'd0);
    chk({pfx, "_mem_addr"},  64'(mem_addr),  64'd0);
    chk({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({pfx, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
    chk({pfx, "_i_gnt"},     64'(i_gnt),     64'd0);
    chk({pfx, "_d_gnt"},     64'(d_gnt),     64'd0);
    chk({pfx, "_i_rvalid"},  64'(i_rvalid),  64'd0);
    chk({pfx, "_d_rvalid"},  64'(d_rvalid),  64'd0);
    chk({pfx, "_i_rdata"},   64'(i_rdata),   64'd0);
    chk({pfx, "_d_rdata"},   64'(d_rdata),   64'd0);
    chk({pfx, "_i_err"},     64'(i_err),     64'd0);
    chk({pfx, "_d_err"},     64'(d_err),     64'd0);
    chk({pfx, "_state"},     64'(dbg_state), 64'd0);
  endtask

  // mid-cycle observation: predict this cycle's outputs from the model
  task automatic monitor();
    logic e_ig, e_dg;
    logic [BC:0] exp_r;
    cyc++;
    if (!reset) begin
      outstanding = 0; in_mem = 0; resp_due = 0; streak = 0; exp_q.delete();
    end
    e_ig = 0; e_dg = 0;
    if (reset && !outstanding) begin
      if (i_req && d_req) begin
        if (streak == SLIM) e_ig = 1; else e_dg = 1;
      end else if (i_req) e_ig = 1;
      else if (d_req) e_dg = 1;
    end
    chk("i_gnt", 64'(i_gnt), 64'(e_ig));
    chk("d_gnt", 64'(d_gnt), 64'(e_dg));
    gnt_i_at_mon = i_gnt;
    chk("i_rvalid", 64'(i_rvalid), 64'(resp_due && !cur_data));
    chk("d_rvalid", 64'(d_rvalid), 64'(resp_due && cur_data));
    if (i_rvalid || d_rvalid) rv_total++;
    if (d_rvalid) d_rv_total++;
    if (resp_due && exp_q.size() > 0) begin
      exp_r = exp_q.pop_front();
      rv_cyc = cyc;
      if (cur_data) begin
        chk("d_rdata", 64'(d_rdata), 64'(exp_r[BC-1:0]));
        chk("d_err", 64'(d_err), 64'(exp_r[BC]));
        last_d_rdata = d_rdata; last_d_err = d_err;
      end else begin
        chk("i_rdata", 64'(i_rdata), 64'(exp_r[BC-1:0]));
        chk("i_err", 64'(i_err), 64'(exp_r[BC]));
        last_i_rdata = i_rdata; last_i_err = i_err;
      end
      resp_due = 0; outstanding = 0;
    end
    chk("mem_req", 64'(mem_req), 64'(in_mem));
    if (in_mem) begin
      chk("mem_we", 64'(mem_we), 64'(f_we));
      chk("mem_addr", 64'(mem_addr), 64'(f_addr));
      chk("mem_wmask", 64'(mem_wmask), 64'(f_wmask));
      if (cur_data) chk("mem_wdata", 64'(mem_wdata), 64'(f_wdata));
      busy_cnt++;
      if (mem_ack) begin
        exp_q.push_back({1'b0, f_we ? '0 : model_mem[f_addr[4:2]]});
        in_mem = 0; resp_due = 1;
      end else if (busy_cnt == TOUT) begin
        exp_q.push_back({1'b1, {BC{1'b0}}});
        in_mem = 0; resp_due = 1;
      end
    end
    if (mem_req) run_len++;
    else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (e_ig || e_dg) begin
      gnt_cyc = cyc; outstanding = 1; in_mem = 1; busy_cnt = 0; cur_data = e_dg;
      if (log_en) grant_log.push_back(d_gnt);
      if (e_dg) begin
        f_we = d_we; f_addr = d_addr; f_wdata = d_wdata; f_wmask = d_wmask;
        streak = i_req ? streak + 1 : 0;
        d_gnt_seen = 1;
        if (d_we) begin
          for (int b = 0; b < 4; b++)
            if (d_wmask[b]) model_mem[d_addr[4:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end
      end else begin
        f_we = 0; f_addr = i_addr; f_wdata = '0; f_wmask = '0;
        streak = 0;
        i_gnt_seen = 1;
      end
    end
  endtask

  // memory responder, driven just after the rising edge
  task automatic respond();
    int idx;
    if (mem_req) begin
      if (!acc_active) begin
        acc_active = 1;
        wait_left = rand_mode ? int'($urandom_range(0, 3)) : next_wait;
      end
      if (hang) begin
        mem_ack = 0; mem_rdata = $urandom;
      end else if (wait_left == 0) begin
        mem_ack = 1; acc_active = 0; idx = int'(mem_addr[4:2]);
        if (mem_we) begin
          mem_rdata = $urandom;
          for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) phys_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          mem_rdata = phys_mem[idx];
        end
      end else begin
        wait_left--; mem_ack = 0; mem_rdata = $urandom;
      end
    end else begin
      acc_active = 0;
      mem_ack = spur ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  endtask

  // requester driver tasks
  task automatic drive();
    if (i_gnt_seen && !keep_req) i_req = 0;
    if (d_gnt_seen && !keep_req) d_req = 0;
    i_gnt_seen = 0; d_gnt_seen = 0;
    if (rand_mode) begin
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = 32'h100 + ($urandom_range(0, 7) << 2);
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'h40 + ($urandom_range(0, 7) << 2);
        d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    respond();
    drive();
  endtask

  task automatic run_until_quiet(input string tag, input int budget);
    logic quiet;
    quiet = 0;
    for (int k = 0; k < budget; k++) begin
      if (!outstanding && !i_req && !d_req) begin
        quiet = 1;
        break;
      end
      cycle();
    end
    if (!outstanding && !i_req && !d_req) quiet = 1;
    chk({tag, "_drain"}, 64'(quiet), 64'd1);
  endtask

  int rv_before, drv_before;

  initial begin
    reset = 0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_ack = 0; mem_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      model_mem[k] = $urandom;
      phys_mem[k]  = model_mem[k];
    end
    model_mem[0] = 32'h00500093;
    phys_mem[0]  = 32'h00500093;
    @(posedge clk); #1;
    cycle(); cycle();
    chk_zero("reset");
    reset = 1;

    // single zero-wait fetch
    next_wait = 0; i_req = 1; i_addr = 32'h100;
    run_until_quiet("fetch", 20);
    chk("fetch_data", 64'(last_i_rdata), 64'h00500093);
    chk("fetch_latency", 64'(rv_cyc - gnt_cyc), 64'd2);

    // store with three wait states
    next_wait = 3; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wmask = 4'hF;
    run_until_quiet("store", 30);
    chk("store_err", 64'(last_d_err), 64'd0);
    chk("store_mem_cycles", 64'(last_run), 64'd4);
    chk("store_latency", 64'(rv_cyc - gnt_cyc), 64'd5);
    next_wait = 0; i_req = 1; i_addr = 32'h100;
    run_until_quiet("readback", 20);
    chk("readback_data", 64'(last_i_rdata), 64'hDEADBEEF);

    // both requesters held: fetch every STARVE_LIMIT+1 grants
    log_en = 1; keep_req = 1; next_wait = 0;
    i_req = 1; i_addr = 32'h104;
    d_req = 1; d_we = 0; d_addr = 32'h44; d_wmask = 4'h0;
    for (int k = 0; k < 200 && grant_log.size() < 10; k++) cycle();
    chk("starve_grants", 64'(grant_log.size() >= 10), 64'd1);
    for (int k = 0; k < 10; k++) begin
      if (k < grant_log.size())
        chk($sformatf("starve_order%0d", k), 64'(grant_log[k]), 64'((k % (SLIM + 1)) != SLIM));
    end
    keep_req = 0; log_en = 0;
    run_until_quiet("starve", 60);

    // hung load aborted by the watchdog, then normal service resumes
    hang = 1; d_req = 1; d_we = 0; d_addr = 32'h48; d_wmask = 4'h3;
    run_until_quiet("timeout", 40);
    chk("timeout_mem_cycles", 64'(last_run), 64'(TOUT));
    chk("timeout_err", 64'(last_d_err), 64'd1);
    chk("timeout_rdata", 64'(last_d_rdata), 64'd0);
    hang = 0; next_wait = 1; i_req = 1; i_addr = 32'h108;
    run_until_quiet("post_timeout", 20);
    chk("post_timeout_err", 64'(last_i_err), 64'd0);
    chk("post_timeout_data", 64'(last_i_rdata), 64'(model_mem[2]));

    // spurious acks while idle
    rv_before = rv_total; spur = 1;
    repeat (10) cycle();
    spur = 0;
    chk("spurious_rvalid", 64'(rv_total - rv_before), 64'd0);

    // randomized traffic
    rand_mode = 1; spur = 1;
    repeat (600) cycle();
    rand_mode = 0; spur = 0;
    run_until_quiet("random", 100);

    // asynchronous reset during BUSY with a fetch pending
    hang = 1; d_req = 1; d_we = 0; d_addr = 32'h4C; d_wmask = 4'h0;
    cycle(); cycle(); cycle();
    i_req = 1; i_addr = 32'h10C;
    #2 reset = 0;
    #1 chk_zero("async_reset");
    drv_before = d_rv_total;
    cycle(); cycle();
    hang = 0; next_wait = 0; reset = 1;
    cycle();
    chk("gnt_after_reset", 64'(gnt_i_at_mon), 64'd1);
    run_until_quiet("after_reset", 20);
    chk("no_stale_d_rvalid", 64'(d_rv_total - drv_before), 64'd0);
    chk("after_reset_data", 64'(last_i_rdata), 64'(model_mem[3]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
